// File: rtl/ama_riscv_mem_wb_stage.sv
// MEM-stage back end: load alignment/extension, writeback select,
// MEM/WB pipeline register and the cycle/instret counters.
module ama_riscv_mem_wb_stage #(
    parameter int          CNT_W    = 64,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_mem,
    input  logic [31:0]      pc_mem,
    input  logic [31:0]      alu_out_mem,
    input  logic [31:0]      dmem_read_data_mem,
    input  logic [1:0]       load_sm_offset_mem,
    input  logic [31:0]      inst_mem,
    input  logic             load_sm_en_mem,
    input  logic [1:0]       wb_sel_mem,
    input  logic [4:0]       rd_addr_mem,
    input  logic             reg_we_mem,
    output logic [31:0]      writeback,
    output logic             reg_we_wb,
    output logic [4:0]       rd_addr_wb,
    output logic [31:0]      wb_data_wb,
    output logic [31:0]      inst_wb,
    output logic [31:0]      pc_wb,
    output logic             load_misaligned_wb,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    logic [2:0]  funct3;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic        misaligned;
    logic        ret;

    assign funct3  = inst_mem[14:12];
    assign shifted = dmem_read_data_mem >> {load_sm_offset_mem, 3'b000};
    assign ret     = !clear_mem && (inst_mem != NOP_INST) &&
                     (inst_mem != 32'h0);

    // Load result: shift to the addressed byte, then sign/zero extend
    always_comb begin
        load_data = dmem_read_data_mem;
        if (load_sm_en_mem) begin
            case (funct3)
                3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
                3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
                3'b010:  load_data = shifted;
                3'b100:  load_data = {24'h0, shifted[7:0]};
                3'b101:  load_data = {16'h0, shifted[15:0]};
                default: load_data = dmem_read_data_mem;
            endcase
        end
    end

    // Misaligned: halfword crossing the word, or any offset word access
    always_comb begin
        misaligned = 1'b0;
        if (load_sm_en_mem) begin
            case (funct3)
                3'b001, 3'b101: misaligned = (load_sm_offset_mem == 2'd3);
                3'b010:         misaligned = (load_sm_offset_mem != 2'd0);
                default:        misaligned = 1'b0;
            endcase
        end
    end

    // Writeback select, combinational for forwarding consumers
    always_comb begin
        writeback = 32'h0;
        case (wb_sel_mem)
            2'd0:    writeback = load_data;
            2'd1:    writeback = alu_out_mem;
            2'd2:    writeback = pc_mem + 32'd4;
            default: writeback = 32'h0;
        endcase
    end

    // MEM/WB register; reset and flush both load a bubble
    always_ff @(posedge clk) begin
        if (rst || clear_mem) begin
            reg_we_wb          <= 1'b0;
            rd_addr_wb         <= 5'd0;
            wb_data_wb         <= 32'h0;
            inst_wb            <= 32'h0;
            pc_wb              <= 32'h0;
            load_misaligned_wb <= 1'b0;
        end else begin
            reg_we_wb          <= reg_we_mem && (rd_addr_mem != 5'd0) &&
                                  !misaligned;
            rd_addr_wb         <= rd_addr_mem;
            wb_data_wb         <= writeback;
            inst_wb            <= inst_mem;
            pc_wb              <= pc_mem;
            load_misaligned_wb <= misaligned;
        end
    end

    // Free-running cycle and retired-instruction counters, wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (ret) instret_cnt <= instret_cnt + CNT_W'(1);
        end
    end

endmodule
